// File: rtl/memory_controller_pkg.sv
// ---------------------------------------------------------------------------
// memory_controller_pkg
// Shared types and helpers for the round-robin memory controller.
//   state_e    : controller FSM states (IDLE, BUSY)
//   WAIT_CNT_W : width of the wait-state down-counter (0..15 wait states)
//   MAX_DEV    : widest requester vector the one-hot helper can produce
//   onehot()   : index -> one-hot vector (MAX_DEV bits, caller truncates)
// ---------------------------------------------------------------------------
package memory_controller_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int WAIT_CNT_W = 4;
  localparam int MAX_DEV    = 32;

  function automatic logic [MAX_DEV-1:0] onehot(input logic [4:0] idx);
    logic [MAX_DEV-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Picks the first asserted request
// at or after ptr_i, wrapping modulo N. The pointer register lives in the
// parent so it only advances when a grant is actually taken.
// Ports:
//   req_i     in  N      request vector
//   ptr_i     in  IDX_W  highest-priority index this cycle
//   grant_o   out IDX_W  granted index (0 when nothing requested)
//   any_req_o out 1      at least one request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_req_o
);

  always_comb begin
    grant_o   = '0;
    any_req_o = |req_i;
    // Walk offsets from farthest to nearest so the nearest requester at or
    // after the pointer is the last (winning) assignment.
    for (int k = N - 1; k >= 0; k--) begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] idx;
      sum = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N)) begin
        sum = sum - (IDX_W + 1)'(N);
      end
      idx = sum[IDX_W-1:0];
      if (req_i[idx]) begin
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/memory_controller_rr.sv
// ---------------------------------------------------------------------------
// memory_controller_rr
// N_DEV requesters share one synchronous RAM through a round-robin arbiter.
// A request is captured in IDLE, waits WAIT_STATES cycles in BUSY, then the
// access happens at the edge that returns to IDLE and the granted requester
// sees a one-cycle ack with the read (or written) data on mem_do.
// Ports:
//   clk      in  1             rising-edge clock
//   reset    in  1             asynchronous active-low reset
//   dev_en   in  N_DEV         per-device request
//   dev_we   in  N_DEV         per-device write enable (1=write)
//   dev_addr in  N_DEV*ADDR_W  flattened addresses, device i at [i*ADDR_W +: ADDR_W]
//   dev_di   in  N_DEV*DATA_W  flattened write data, same packing
//   dev_ack  out N_DEV         registered one-hot ack pulse
//   mem_do   out DATA_W        registered data of the last acked transaction
//   busy     out 1             high while a transaction is captured
// ---------------------------------------------------------------------------
module memory_controller_rr
  import memory_controller_pkg::*;
#(
  parameter int N_DEV       = 3,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_DEV-1:0]         dev_en,
  input  logic [N_DEV-1:0]         dev_we,
  input  logic [N_DEV*ADDR_W-1:0]  dev_addr,
  input  logic [N_DEV*DATA_W-1:0]  dev_di,
  output logic [N_DEV-1:0]         dev_ack,
  output logic [DATA_W-1:0]        mem_do,
  output logic                     busy
);

  localparam int IDX_W  = $clog2(N_DEV);
  localparam int RAM_AW = $clog2(DEPTH);

  // Unpacked views of the flattened request buses.
  logic [ADDR_W-1:0] addr_arr [N_DEV];
  logic [DATA_W-1:0] di_arr   [N_DEV];

  genvar gi;
  generate
    for (gi = 0; gi < N_DEV; gi++) begin : g_unpack
      assign addr_arr[gi] = dev_addr[gi*ADDR_W +: ADDR_W];
      assign di_arr[gi]   = dev_di[gi*DATA_W +: DATA_W];
    end
  endgenerate

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q,   cnt_d;
  logic [IDX_W-1:0]        gnt_q,   gnt_d;
  logic [IDX_W-1:0]        ptr_q,   ptr_d;
  logic                    we_q,    we_d;
  logic [ADDR_W-1:0]       addr_q,  addr_d;
  logic [DATA_W-1:0]       di_q,    di_d;
  logic [N_DEV-1:0]        ack_q,   ack_d;
  logic [DATA_W-1:0]       mem_do_q;

  logic [DATA_W-1:0]       ram [DEPTH];

  logic [IDX_W-1:0]        arb_grant;
  logic                    arb_any;
  logic                    access;
  logic                    in_range;
  logic [RAM_AW-1:0]       ram_idx;

  rr_arbiter #(
    .N     (N_DEV),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i     (dev_en),
    .ptr_i     (ptr_q),
    .grant_o   (arb_grant),
    .any_req_o (arb_any)
  );

  // The access edge is the last BUSY cycle; everything that touches the RAM
  // or mem_do keys off this.
  assign access   = (state_q == BUSY) && (cnt_q == '0);
  assign in_range = ({1'b0, addr_q} < (ADDR_W + 1)'(DEPTH));
  assign ram_idx  = addr_q[RAM_AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    di_d    = di_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_grant;
          we_d    = dev_we[arb_grant];
          addr_d  = addr_arr[arb_grant];
          di_d    = di_arr[arb_grant];
          cnt_d   = WAIT_CNT_W'(WAIT_STATES);
          ptr_d   = (arb_grant == IDX_W'(N_DEV - 1)) ? '0 : arb_grant + 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          ack_d   = N_DEV'(onehot(5'(gnt_q)));
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      ptr_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      di_q     <= '0;
      ack_q    <= '0;
      mem_do_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      ack_q   <= ack_d;
      // Registered RAM read; out-of-range reads return zero.
      if (access) begin
        if (we_q) begin
          mem_do_q <= di_q;
        end else if (in_range) begin
          mem_do_q <= ram[ram_idx];
        end else begin
          mem_do_q <= '0;
        end
      end
    end
  end

  // RAM contents are never reset. A reset during BUSY forces state_q to IDLE
  // asynchronously, so access is low by the edge that would have written.
  always_ff @(posedge clk) begin
    if (access && we_q && in_range) begin
      ram[ram_idx] <= di_q;
    end
  end

  assign dev_ack = ack_q;
  assign mem_do  = mem_do_q;
  assign busy    = (state_q == BUSY);

endmodule

// File: doc/memory_controller_rr.md
Name: memory_controller_rr

Overview:
Parametrised successor to the fixed 3-device memory controller. N_DEV requesters share one on-chip synchronous RAM through a round-robin arbiter. A programmable wait-state counter sits between grant and access. Each requester gets a one-cycle ack pulse, with read data on a shared bus. Sits between bus masters (CPU fetch/LSU, DMA) and local SRAM.

Parameters:
N_DEV, 3, number of requesters (>=2)
ADDR_W, 8, address width per requester
DATA_W, 8, data word width
DEPTH, 256, implemented words (<= 2**ADDR_W); addresses >= DEPTH are out of range
WAIT_STATES, 0, extra cycles between grant and access (0..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
dev_en  in  N_DEV  per-device request
dev_we  in  N_DEV  per-device write enable (1=write, 0=read)
dev_addr  in  N_DEV*ADDR_W  flattened addresses, device i at [i*ADDR_W +: ADDR_W]
dev_di  in  N_DEV*DATA_W  flattened write data, same packing
dev_ack  out  N_DEV  one-hot ack pulse, registered
mem_do  out  DATA_W  read data / written data of acked transaction, registered
busy  out  1  high while a transaction is captured (BUSY state)

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, dev_ack=0, mem_do=0, busy=0, rr pointer=0 (device 0 highest priority). RAM contents not reset.
- States: IDLE, BUSY. The ack cycle is the IDLE cycle following BUSY; no separate state.
- IDLE, edge with any dev_en high:
  - grant g = first requester at or after pointer (wrapping mod N_DEV).
  - Capture g, addr, di, we.
  - Set cnt=WAIT_STATES, busy=1, pointer=(g+1) mod N_DEV, go to BUSY.
- IDLE, no request: hold state. dev_ack returns to 0 at that edge.
- BUSY, cnt>0: cnt decrements at each edge.
- BUSY, cnt==0, at that edge:
  - Write: RAM[addr]<=di; mem_do<=di.
  - Read: mem_do<=RAM[addr].
  - dev_ack<=one-hot(g); busy<=0; state<=IDLE.
- Next edge: dev_ack cleared; arbitration runs again in the same edge.
- Latency: en sampled at edge k, dev_ack high after edge k+1+WAIT_STATES for exactly one cycle. Back-to-back throughput: one transaction per WAIT_STATES+2 cycles.
- Requester must drop dev_en in its ack cycle. If still high at the next edge, it is a new request, arbitrated after all others (pointer has moved).
- dev_en dropped while captured: the transaction still completes and acks; inputs are only sampled at grant.
- Out-of-range address (>= DEPTH): write discarded, read returns 0, ack still given.
- mem_do holds its last value between acks.
- Reset mid-BUSY: transaction aborted, no ack, no RAM write (write occurs only at the access edge).
- dev_we/di/addr of non-granted devices are ignored.

Decomposition:
- Package memory_controller_pkg: state enum (IDLE, BUSY), WAIT_CNT_W=4, helper function for one-hot of index.
- Sub-module rr_arbiter (N parametrised):
  - inputs: req[N], pointer.
  - outputs: grant index, any_req.
  - Purely combinational rotate/priority-encode; the pointer register lives in the parent.

Test Plan:
1. Drive reset=0 mid-cycle while BUSY -> dev_ack=0, mem_do=0, busy=0 immediately (before next edge).
2. Defaults; devices 0/1/2 write addr 0x0A/0x0B/0x0C data 42/43/44 simultaneously, each dropping en on own ack -> acks 001,010,100 at 2-cycle spacing. Then reads of same addresses -> mem_do 42,43,44.
3. Devices 0 and 2 hold dev_en continuously reading addr 5 -> ack sequence 001,100,001,100 (device 1 never acked, never starved among requesters).
4. WAIT_STATES=3; device 1 reads addr 0x0B sampled at edge k -> busy high k..k+4, dev_ack=010 only after edge k+4, mem_do=43.
5. DEPTH=200; write addr 250 data 9 -> ack given. Read 250 -> mem_do=0. Read 199 after writing 17 -> 17.
6. Write addr 5 data 7 with WAIT_STATES=2, reset pulsed during BUSY -> no ack. After reset, read addr 5 returns its previous value (pre-written 3).
